// File: rtl/lsid_req_arbiter_pkg.sv
// Shared types for the D-tile LSID request arbiter: LSID/data types, the
// arbitrated request record and the LSID table depth.
package lsid_req_arbiter_pkg;

  localparam int LSID_BITS = 5;
  localparam int ADDR_BITS = 32;
  localparam int NUM_LSID  = 1 << LSID_BITS;

  typedef logic [LSID_BITS-1:0] lsid_t;
  typedef logic [63:0]          reg_data_t;

  typedef struct packed {
    logic                 is_load;
    lsid_t                lsid;
    logic [ADDR_BITS-1:0] addr;
    reg_data_t            data;
  } arb_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first eligible
// requester at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             found
);

  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsid_req_arbiter.sv
// Round-robin arbiter sharing the LSID unit load/store port among E-tiles,
// one in-flight op per LSID. Define LSID_ARB_PERF_CNT_EN for grant/stall counters.
module lsid_req_arbiter
  import lsid_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LSID_W  = LSID_BITS,
  parameter int ADDR_W  = ADDR_BITS,
  parameter int DATA_W  = $bits(reg_data_t)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_is_load,
  input  logic [NUM_REQ*LSID_W-1:0] req_lsid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      mem_load_req,
  output logic                      mem_store_req,
  output logic [LSID_W-1:0]         mem_lsid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_store_data,
  input  logic                      mem_ready,
  input  logic                      rsp_valid,
  input  logic [LSID_W-1:0]         rsp_lsid,
  input  logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [LSID_W-1:0]         resp_lsid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      rsp_err
`ifdef LSID_ARB_PERF_CNT_EN
  ,
  output logic [31:0]               grant_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_LSID-1:0] busy;
  logic [IDX_W-1:0]    owner [NUM_LSID];
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                found;
  logic                grant;
  logic                issue_done;
  arb_req_t            win_req;
  arb_req_t            req_p1;
  logic                vld_p1;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && !busy[req_lsid[i*LSID_W +: LSID_W]];
    end
  end

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant_oh),
    .found    (found)
  );

  // A full output stage may only be refilled in the cycle it drains.
  assign issue_done = vld_p1 && mem_ready;
  assign grant      = found && (!vld_p1 || mem_ready);
  assign req_ready  = grant ? grant_oh : '0;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) win_idx = IDX_W'(i);
    end
    win_req.is_load = req_is_load[win_idx];
    win_req.lsid    = req_lsid[int'(win_idx)*LSID_W +: LSID_W];
    win_req.addr    = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_req.data    = req_data[int'(win_idx)*DATA_W +: DATA_W];
  end

  // ---- stage p1: registered issue toward the LSID unit ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      req_p1 <= '0;
    end else if (grant) begin
      vld_p1 <= 1'b1;
      req_p1 <= win_req;
    end else if (issue_done) begin
      vld_p1 <= 1'b0;
    end
  end

  assign mem_load_req   = vld_p1 && req_p1.is_load;
  assign mem_store_req  = vld_p1 && !req_p1.is_load;
  assign mem_lsid       = req_p1.lsid;
  assign mem_addr       = req_p1.addr;
  assign mem_store_data = req_p1.data;

  // Grant and response never hit the same busy bit: a busy LSID cannot win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      rr_ptr <= '0;
      for (int l = 0; l < NUM_LSID; l++) owner[l] <= '0;
    end else begin
      if (rsp_valid && busy[rsp_lsid]) busy[rsp_lsid] <= 1'b0;
      if (grant) begin
        busy[win_req.lsid]  <= 1'b1;
        owner[win_req.lsid] <= win_idx;
        rr_ptr <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_lsid  <= '0;
      resp_data  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (rsp_valid) begin
        resp_lsid <= rsp_lsid;
        resp_data <= rsp_data;
        if (busy[rsp_lsid]) resp_valid <= NUM_REQ'(1) << owner[rsp_lsid];
        else                rsp_err    <= 1'b1;
      end
    end
  end

`ifdef LSID_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue_done) grant_cnt <= grant_cnt + 32'd1;
      if (|req_valid && !grant) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsid_req_arbiter.sv
// Directed bench for lsid_req_arbiter: reset, single op, round-robin order,
// same-LSID stall, backpressure, bad response and mid-operation reset.
module tb_lsid_req_arbiter;

  localparam int NR = 4;
  localparam int LW = 5;
  localparam int AW = 32;
  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid, req_ready, req_is_load;
  logic [NR*LW-1:0] req_lsid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic             mem_load_req, mem_store_req, mem_ready;
  logic [LW-1:0]    mem_lsid;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_store_data;
  logic             rsp_valid;
  logic [LW-1:0]    rsp_lsid;
  logic [DW-1:0]    rsp_data;
  logic [NR-1:0]    resp_valid;
  logic [LW-1:0]    resp_lsid;
  logic [DW-1:0]    resp_data;
  logic             rsp_err;
`ifdef LSID_ARB_PERF_CNT_EN
  logic [31:0]      grant_cnt, stall_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  lsid_req_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_load    (req_is_load),
    .req_lsid       (req_lsid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .mem_load_req   (mem_load_req),
    .mem_store_req  (mem_store_req),
    .mem_lsid       (mem_lsid),
    .mem_addr       (mem_addr),
    .mem_store_data (mem_store_data),
    .mem_ready      (mem_ready),
    .rsp_valid      (rsp_valid),
    .rsp_lsid       (rsp_lsid),
    .rsp_data       (rsp_data),
    .resp_valid     (resp_valid),
    .resp_lsid      (resp_lsid),
    .resp_data      (resp_data),
    .rsp_err        (rsp_err)
`ifdef LSID_ARB_PERF_CNT_EN
    ,
    .grant_cnt      (grant_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic ld, input logic [LW-1:0] l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_is_load[i]         = ld;
    req_lsid[i*LW +: LW]   = l;
    req_addr[i*AW +: AW]   = a;
    req_data[i*DW +: DW]   = d;
  endtask

  // Drives one response cycle; registered results are visible on return.
  task automatic send_rsp(input logic [LW-1:0] l, input logic [DW-1:0] d);
    rsp_valid = 1'b1;
    rsp_lsid  = l;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_is_load = '0; req_lsid = '0; req_addr = '0; req_data = '0;
    mem_ready = 1'b1; rsp_valid = 1'b0; rsp_lsid = '0; rsp_data = '0;
    tick(); tick();
    vectors++;
    if ({mem_load_req, mem_store_req, mem_lsid, mem_addr, mem_store_data} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got %0h expected 0",
               {mem_load_req, mem_store_req, mem_lsid, mem_addr, mem_store_data});
    end
    vectors++;
    if ({resp_valid, resp_lsid, resp_data, rsp_err, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_resp: got %0h expected 0", {resp_valid, resp_lsid, resp_data, rsp_err, req_ready});
    end
`ifdef LSID_ARB_PERF_CNT_EN
    vectors++;
    if ({grant_cnt, stall_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0h expected 0", {grant_cnt, stall_cnt});
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    set_req(0, 1'b1, 1'b1, 5'd3, 32'h100, 64'h0);
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    vectors++;
    if ({mem_load_req, mem_store_req, mem_lsid, mem_addr} !== {1'b1, 1'b0, 5'd3, 32'h100}) begin
      errors++;
      $display("FAIL single_issue: got ld=%b st=%b lsid=%0d addr=%0h expected ld=1 st=0 lsid=3 addr=100",
               mem_load_req, mem_store_req, mem_lsid, mem_addr);
    end
    tick();
    vectors++;
    if (mem_load_req !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", mem_load_req); end
    send_rsp(5'd3, 64'hAB);
    vectors++;
    if ({resp_valid, resp_lsid, resp_data} !== {4'b0001, 5'd3, 64'hAB}) begin
      errors++;
      $display("FAIL single_resp: got v=%b lsid=%0d data=%0h expected v=0001 lsid=3 data=ab",
               resp_valid, resp_lsid, resp_data);
    end
    tick();
    vectors++;
    if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_pulse: got %b expected 0000", resp_valid); end
  endtask

  task automatic test_round_robin();
    int order_a[4] = '{1, 2, 3, 0};
    logic [NR-1:0] exp_oh;
    // Pointer is 1 after the single-load test.
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, LW'(i), 32'h1000 + i, 64'h0);
    for (int s = 0; s < NR; s++) begin
      #1;
      exp_oh = 4'b0001 << order_a[s];
      vectors++;
      if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_a_grant%0d: got %b expected %b", s, req_ready, exp_oh); end
      tick();
      req_valid[order_a[s]] = 1'b0;
      vectors++;
      if (mem_lsid !== LW'(order_a[s])) begin errors++; $display("FAIL rr_a_lsid%0d: got %0d expected %0d", s, mem_lsid, order_a[s]); end
    end
    tick();
    for (int k = 0; k < NR; k++) begin
      send_rsp(LW'(k), 64'h50 + k);
      exp_oh = 4'b0001 << k;
      vectors++;
      if ({resp_valid, resp_data} !== {exp_oh, 64'h50 + k}) begin
        errors++;
        $display("FAIL rr_route%0d: got v=%b data=%0h expected v=%b data=%0h", k, resp_valid, resp_data, exp_oh, 64'h50 + k);
      end
    end
    // A grant to requester 3 brings the pointer back to 0.
    set_req(3, 1'b1, 1'b0, 5'd20, 32'h2000, 64'h77);
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL rr_wrap_grant: got %b expected 1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    vectors++;
    if (mem_store_req !== 1'b1) begin errors++; $display("FAIL rr_wrap_store: got %b expected 1", mem_store_req); end
    tick();
    send_rsp(5'd20, 64'h0);
    vectors++;
    if (resp_valid !== 4'b1000) begin errors++; $display("FAIL rr_wrap_resp: got %b expected 1000", resp_valid); end
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, LW'(10 + i), 32'h3000 + i, 64'h0);
    for (int s = 0; s < NR; s++) begin
      #1;
      exp_oh = 4'b0001 << s;
      vectors++;
      if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_b_grant%0d: got %b expected %b", s, req_ready, exp_oh); end
      tick();
      req_valid[s] = 1'b0;
      vectors++;
      if (mem_addr !== 32'h3000 + s) begin errors++; $display("FAIL rr_b_addr%0d: got %0h expected %0h", s, mem_addr, 32'h3000 + s); end
    end
    tick();
    for (int k = 0; k < NR; k++) begin
      send_rsp(LW'(10 + k), 64'h0);
      exp_oh = 4'b0001 << k;
      vectors++;
      if (resp_valid !== exp_oh) begin errors++; $display("FAIL rr_b_route%0d: got %b expected %b", k, resp_valid, exp_oh); end
    end
  endtask

  task automatic test_same_lsid();
    // Pointer is 0 here.
    set_req(1, 1'b1, 1'b1, 5'd7, 32'h700, 64'h0);
    set_req(2, 1'b1, 1'b1, 5'd7, 32'h780, 64'h0);
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL same_first: got %b expected 0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    vectors++;
    if ({mem_lsid, mem_addr} !== {5'd7, 32'h700}) begin
      errors++; $display("FAIL same_issue1: got lsid=%0d addr=%0h expected lsid=7 addr=700", mem_lsid, mem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL same_stall%0d: got %b expected 0000", c, req_ready); end
      tick();
    end
    rsp_valid = 1'b1; rsp_lsid = 5'd7; rsp_data = 64'h1234;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL same_rsp_cycle: got %b expected 0000", req_ready); end
    tick();
    rsp_valid = 1'b0;
    #1;
    vectors++;
    if ({resp_valid, req_ready} !== {4'b0010, 4'b0100}) begin
      errors++; $display("FAIL same_after_rsp: got resp=%b ready=%b expected resp=0010 ready=0100", resp_valid, req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    vectors++;
    if ({mem_load_req, mem_lsid, mem_addr} !== {1'b1, 5'd7, 32'h780}) begin
      errors++; $display("FAIL same_issue2: got ld=%b lsid=%0d addr=%0h expected ld=1 lsid=7 addr=780", mem_load_req, mem_lsid, mem_addr);
    end
    tick();
    send_rsp(5'd7, 64'h0);
    vectors++;
    if (resp_valid !== 4'b0100) begin errors++; $display("FAIL same_resp2: got %b expected 0100", resp_valid); end
  endtask

  task automatic test_backpressure();
    // Pointer is 3 here; requester 0 is the first eligible.
    mem_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 5'd2, 32'h200, 64'hDEADBEEF_CAFEF00D);
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b1, 5'd5, 32'h500, 64'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({mem_store_req, mem_addr, mem_store_data, req_ready} !== {1'b1, 32'h200, 64'hDEADBEEF_CAFEF00D, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold%0d: got st=%b addr=%0h data=%0h ready=%b expected st=1 addr=200 data=deadbeefcafef00d ready=0000",
                 c, mem_store_req, mem_addr, mem_store_data, req_ready);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    vectors++;
    if ({mem_store_req, req_ready} !== {1'b1, 4'b0010}) begin
      errors++; $display("FAIL bp_release: got st=%b ready=%b expected st=1 ready=0010", mem_store_req, req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    vectors++;
    if ({mem_load_req, mem_store_req, mem_lsid} !== {1'b1, 1'b0, 5'd5}) begin
      errors++; $display("FAIL bp_next: got ld=%b st=%b lsid=%0d expected ld=1 st=0 lsid=5", mem_load_req, mem_store_req, mem_lsid);
    end
    tick();
  endtask

  task automatic test_bad_rsp();
    send_rsp(5'd9, 64'hFF);
    vectors++;
    if ({rsp_err, resp_valid} !== {1'b1, 4'b0000}) begin
      errors++; $display("FAIL bad_rsp: got err=%b resp=%b expected err=1 resp=0000", rsp_err, resp_valid);
    end
    tick(); tick();
    vectors++;
    if (rsp_err !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b expected 1", rsp_err); end
  endtask

  task automatic test_reset_mid();
    // LSIDs 2 and 5 are still busy; park a store in the output stage too.
    set_req(3, 1'b1, 1'b0, 5'd6, 32'h600, 64'h66);
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_grant: got %b expected 1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_load_req, mem_store_req, mem_lsid, mem_addr, mem_store_data, rsp_err, resp_valid} !== '0) begin
      errors++;
      $display("FAIL mid_reset_out: got st=%b lsid=%0d addr=%0h err=%b expected all 0", mem_store_req, mem_lsid, mem_addr, rsp_err);
    end
`ifdef LSID_ARB_PERF_CNT_EN
    vectors++;
    if ({grant_cnt, stall_cnt} !== 64'd0) begin
      errors++; $display("FAIL mid_reset_cnt: got %0h expected 0", {grant_cnt, stall_cnt});
    end
`endif
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    set_req(0, 1'b1, 1'b1, 5'd2, 32'h220, 64'h0);
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b expected 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    vectors++;
    if ({mem_load_req, mem_lsid, mem_addr} !== {1'b1, 5'd2, 32'h220}) begin
      errors++; $display("FAIL mid_reissue: got ld=%b lsid=%0d addr=%0h expected ld=1 lsid=2 addr=220", mem_load_req, mem_lsid, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_round_robin();
    test_same_lsid();
    test_backpressure();
    test_bad_rsp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
